i2c_line_driver: RTL and testbench

I2C_LINE_DRIVER -- requirements
Module: i2c_line_driver

---
 rtl/i2c_line_driver.sv | 152 +++++++++++++++
 tb/tb_i2c_line_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_line_driver.sv
// Open-drain I2C line driver: drives a requested level, waits HOLD_CYCLES to settle, then checks the read-back.
// Optional stretch timeout in CHECK is enabled by defining I2C_STRETCH_TIMEOUT_EN.
module i2c_line_driver #(
  parameter int unsigned HOLD_CYCLES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic fastClock,
  input  logic reset,
  input  logic requestLevel,
  input  logic requestValid,
  output logic requestReady,
  input  logic lineIn,
  output logic driveLow,
  output logic stretchDetected,
  output logic mismatch,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  // Out-of-range parameters stop elaboration instead of silently truncating.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_badHold
    $error("HOLD_CYCLES must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t     r_state, w_stateNext;
  logic       r_level, w_levelNext;
  logic [7:0] r_holdCnt, w_holdCntNext;
  logic       r_ready, w_readyNext;
  logic       r_driveLow, w_driveLowNext;
  logic       r_stretch, w_stretchNext;
  logic       r_mismatch, w_mismatchNext;
  logic       r_done, w_doneNext;

`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_toCnt, w_toCntNext;
`endif

  always_ff @(posedge fastClock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_level    <= 1'b0;
      r_holdCnt  <= 8'd0;
      r_ready    <= 1'b1;
      r_driveLow <= 1'b0;
      r_stretch  <= 1'b0;
      r_mismatch <= 1'b0;
      r_done     <= 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
      r_toCnt    <= 8'd0;
`endif
    end else begin
      r_state    <= w_stateNext;
      r_level    <= w_levelNext;
      r_holdCnt  <= w_holdCntNext;
      r_ready    <= w_readyNext;
      r_driveLow <= w_driveLowNext;
      r_stretch  <= w_stretchNext;
      r_mismatch <= w_mismatchNext;
      r_done     <= w_doneNext;
`ifdef I2C_STRETCH_TIMEOUT_EN
      r_toCnt    <= w_toCntNext;
`endif
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_levelNext    = r_level;
    w_holdCntNext  = r_holdCnt;
    w_driveLowNext = r_driveLow;
    w_stretchNext  = r_stretch;
    w_mismatchNext = 1'b0;
    w_doneNext     = 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
    w_toCntNext    = r_toCnt;
`endif

    unique case (r_state)
      IDLE: begin
        if (requestValid && r_ready) begin
          w_levelNext    = requestLevel;
          w_driveLowNext = ~requestLevel;
          w_holdCntNext  = HOLD_LOAD;
          w_stateNext    = SETTLE;
        end
      end

      SETTLE: begin
        if (r_holdCnt == 8'd0) begin
          w_stateNext = CHECK;
`ifdef I2C_STRETCH_TIMEOUT_EN
          w_toCntNext = 8'd0;
`endif
        end else begin
          w_holdCntNext = r_holdCnt - 8'd1;
        end
      end

      CHECK: begin
        if (lineIn == r_level) begin
          w_doneNext    = 1'b1;
          w_stretchNext = 1'b0;
          w_stateNext   = IDLE;
        end else if (!r_level) begin
          // Pulling low but the line reads high: something else is fighting us.
          w_mismatchNext = 1'b1;
          w_stateNext    = IDLE;
        end else begin
          // Released but still low: another device is stretching the line.
`ifdef I2C_STRETCH_TIMEOUT_EN
          if (r_toCnt == TIMEOUT_LAST) begin
            w_mismatchNext = 1'b1;
            w_stretchNext  = 1'b0;
            w_driveLowNext = 1'b0;
            w_toCntNext    = 8'd0;
            w_stateNext    = IDLE;
          end else begin
            w_toCntNext   = r_toCnt + 8'd1;
            w_stretchNext = 1'b1;
          end
`else
          w_stretchNext = 1'b1;
`endif
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase

    w_readyNext = (w_stateNext == IDLE);
  end

  assign requestReady    = r_ready;
  assign driveLow        = r_driveLow;
  assign stretchDetected = r_stretch;
  assign mismatch        = r_mismatch;
  assign done            = r_done;

endmodule

// File: tb/tb_i2c_line_driver.sv
// Directed self-checking bench for i2c_line_driver (HOLD_CYCLES=3, TIMEOUT_CYCLES=4).
// Define I2C_STRETCH_TIMEOUT_EN to exercise the stretch timeout instead of the long stretch.
module tb_i2c_line_driver;

  logic fastClock = 1'b0;
  logic reset = 1'b1;
  logic requestLevel = 1'b1;
  logic requestValid = 1'b0;
  logic requestReady;
  logic lineIn = 1'b1;
  logic driveLow;
  logic stretchDetected;
  logic mismatch;
  logic done;

  int tests = 0;
  int failures = 0;

  i2c_line_driver #(
    .HOLD_CYCLES(3),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .fastClock(fastClock),
    .reset(reset),
    .requestLevel(requestLevel),
    .requestValid(requestValid),
    .requestReady(requestReady),
    .lineIn(lineIn),
    .driveLow(driveLow),
    .stretchDetected(stretchDetected),
    .mismatch(mismatch),
    .done(done)
  );

  always #5 fastClock = ~fastClock;

  // Advance one rising edge and settle just after it, where outputs are sampled and inputs changed.
  task automatic tick();
    @(posedge fastClock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    requestValid = 1'b1;
    requestLevel = 1'b0;
    tick();
    tick();
    tests++; if (requestReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", requestReady); end
    tests++; if (driveLow !== 1'b0) begin failures++; $display("[TB] FAIL reset_driveLow: got %b expected 0", driveLow); end
    tests++; if (stretchDetected !== 1'b0) begin failures++; $display("[TB] FAIL reset_stretch: got %b expected 0", stretchDetected); end
    tests++; if (mismatch !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL reset_pulses: got mismatch=%b done=%b expected 0 0", mismatch, done); end
    requestValid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_drive_low();
    requestLevel = 1'b0;
    requestValid = 1'b1;
    lineIn = 1'b1;
    tick();  // T
    tests++; if (driveLow !== 1'b1) begin failures++; $display("[TB] FAIL low_driveLow_T: got %b expected 1", driveLow); end
    tests++; if (requestReady !== 1'b0) begin failures++; $display("[TB] FAIL low_ready_T: got %b expected 0", requestReady); end
    requestValid = 1'b0;
    lineIn = 1'b0;
    tick();  // T+1
    tick();  // T+2
    tick();  // T+3, CHECK now visible
    tests++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL low_done_early: got %b expected 0", done); end
    tick();  // T+4
    tests++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL low_done: got %b expected 1", done); end
    tests++; if (requestReady !== 1'b1) begin failures++; $display("[TB] FAIL low_ready_done: got %b expected 1", requestReady); end
    tests++; if (mismatch !== 1'b0) begin failures++; $display("[TB] FAIL low_mismatch: got %b expected 0", mismatch); end
    tick();  // T+5
    tests++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL low_done_width: got %b expected 0", done); end
    tests++; if (driveLow !== 1'b1) begin failures++; $display("[TB] FAIL low_driveLow_hold: got %b expected 1", driveLow); end
  endtask

  task automatic test_stretch();
    requestLevel = 1'b1;
    requestValid = 1'b1;
    lineIn = 1'b0;
    tick();  // T
    tests++; if (driveLow !== 1'b0) begin failures++; $display("[TB] FAIL str_driveLow_T: got %b expected 0", driveLow); end
    requestValid = 1'b0;
    tick();
    tick();
    tick();  // T+3
    tests++; if (stretchDetected !== 1'b0) begin failures++; $display("[TB] FAIL str_early: got %b expected 0", stretchDetected); end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if (stretchDetected !== 1'b1 || done !== 1'b0 || mismatch !== 1'b0) begin failures++; $display("[TB] FAIL str_cycle%0d: got stretch=%b done=%b mismatch=%b expected 1 0 0", i, stretchDetected, done, mismatch); end
    end
    lineIn = 1'b1;
    tick();
    tests++; if (done !== 1'b1 || stretchDetected !== 1'b0 || mismatch !== 1'b0) begin failures++; $display("[TB] FAIL str_done: got done=%b stretch=%b mismatch=%b expected 1 0 0", done, stretchDetected, mismatch); end
    tick();
    tests++; if (done !== 1'b0 || requestReady !== 1'b1) begin failures++; $display("[TB] FAIL str_after: got done=%b ready=%b expected 0 1", done, requestReady); end
  endtask

  task automatic test_timeout();
    requestLevel = 1'b1;
    requestValid = 1'b1;
    lineIn = 1'b0;
    tick();  // T
    requestValid = 1'b0;
    tick();
    tick();
    tick();  // T+3
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (stretchDetected !== 1'b1 || mismatch !== 1'b0) begin failures++; $display("[TB] FAIL to_cycle%0d: got stretch=%b mismatch=%b expected 1 0", i, stretchDetected, mismatch); end
    end
    tick();  // fourth stretch edge
    tests++; if (mismatch !== 1'b1 || stretchDetected !== 1'b0) begin failures++; $display("[TB] FAIL to_fire: got mismatch=%b stretch=%b expected 1 0", mismatch, stretchDetected); end
    tests++; if (driveLow !== 1'b0 || requestReady !== 1'b1 || done !== 1'b0) begin failures++; $display("[TB] FAIL to_state: got driveLow=%b ready=%b done=%b expected 0 1 0", driveLow, requestReady, done); end
    tick();
    tests++; if (mismatch !== 1'b0) begin failures++; $display("[TB] FAIL to_width: got %b expected 0", mismatch); end
    lineIn = 1'b1;
  endtask

  task automatic test_mismatch();
    requestLevel = 1'b0;
    requestValid = 1'b1;
    lineIn = 1'b1;
    tick();  // T
    requestValid = 1'b0;
    tick();
    tick();
    tick();  // T+3, lineIn wrong throughout SETTLE
    tests++; if (mismatch !== 1'b0) begin failures++; $display("[TB] FAIL mm_settle: got %b expected 0", mismatch); end
    tick();  // T+4
    tests++; if (mismatch !== 1'b1 || done !== 1'b0) begin failures++; $display("[TB] FAIL mm_pulse: got mismatch=%b done=%b expected 1 0", mismatch, done); end
    tests++; if (driveLow !== 1'b1 || requestReady !== 1'b1) begin failures++; $display("[TB] FAIL mm_state: got driveLow=%b ready=%b expected 1 1", driveLow, requestReady); end
    tick();
    tests++; if (mismatch !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL mm_width: got mismatch=%b done=%b expected 0 0", mismatch, done); end
  endtask

  task automatic test_back_to_back();
    requestLevel = 1'b0;
    requestValid = 1'b1;
    lineIn = 1'b0;
    tick();  // T: level 0 accepted
    requestLevel = 1'b1;  // valid stays high; must be dropped until IDLE
    tick();
    tests++; if (driveLow !== 1'b1 || requestReady !== 1'b0) begin failures++; $display("[TB] FAIL b2b_no_queue: got driveLow=%b ready=%b expected 1 0", driveLow, requestReady); end
    tick();
    tick();
    tick();  // T+4
    tests++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done1: got %b expected 1", done); end
    tick();  // T+5: level 1 accepted
    tests++; if (driveLow !== 1'b0 || requestReady !== 1'b0) begin failures++; $display("[TB] FAIL b2b_accept2: got driveLow=%b ready=%b expected 0 0", driveLow, requestReady); end
    requestValid = 1'b0;
    lineIn = 1'b1;
    tick();
    tick();
    tick();
    tick();  // T+9
    tests++; if (done !== 1'b1 || mismatch !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done2: got done=%b mismatch=%b expected 1 0", done, mismatch); end
    tick();
  endtask

  task automatic test_reset_mid_settle();
    requestLevel = 1'b0;
    requestValid = 1'b1;
    lineIn = 1'b0;
    tick();  // T
    tests++; if (driveLow !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_drive: got %b expected 1", driveLow); end
    requestLevel = 1'b1;
    tick();  // T+1, pulse during SETTLE dropped
    tests++; if (driveLow !== 1'b1 || requestReady !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_drop: got driveLow=%b ready=%b expected 1 0", driveLow, requestReady); end
    requestValid = 1'b0;
    reset = 1'b1;
    tick();
    tests++; if (driveLow !== 1'b0 || requestReady !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_state: got driveLow=%b ready=%b expected 0 1", driveLow, requestReady); end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (done !== 1'b0 || mismatch !== 1'b0 || driveLow !== 1'b0 || requestReady !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_quiet%0d: got done=%b mismatch=%b driveLow=%b ready=%b expected 0 0 0 1", i, done, mismatch, driveLow, requestReady); end
    end
  endtask

  initial begin
    test_reset();
    test_drive_low();
`ifdef I2C_STRETCH_TIMEOUT_EN
    test_timeout();
`else
    test_stretch();
`endif
    test_mismatch();
    test_back_to_back();
    test_reset_mid_settle();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
